// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types and constants for the USB TX line path
package usb_tx_pkg;

  localparam int USB_STUFF_LEN = 6;

  typedef enum logic [1:0] {
    LINE_J,
    LINE_K,
    LINE_SE0
  } line_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_STUFF,
    ST_SE0,
    ST_EOP_J
  } enc_state_t;

  function automatic line_t level_to_line(input logic level);
    return level ? LINE_J : LINE_K;
  endfunction

  // Pin pair {dp, dm} for a line state
  function automatic logic [1:0] line_pins(input line_t line);
    case (line)
      LINE_K:   return 2'b01;
      LINE_SE0: return 2'b00;
      default:  return 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - saturating up-counter with synchronous clear
module flex_counter #(
  parameter int NUM_CNT_BITS = 3
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear_i,
  input  logic                    count_enable_i,
  input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
  output logic [NUM_CNT_BITS-1:0] count_o
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_enable_i && (count_q != rollover_val_i)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/usb_tx_line_encoder.sv
// rtl/usb_tx_line_encoder.sv - bit stuffing, NRZI encoding and EOP generation for the USB TX pins
module usb_tx_line_encoder
  import usb_tx_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic clk,
  input  logic n_rst,
  input  logic bit_strobe,
  input  logic tx_active,
  input  logic raw_dp,
  input  logic raw_dm,
  output logic stall,
  output logic dp_out,
  output logic dm_out,
  output logic eop_done,
  output logic line_err
);

  localparam int CNT_W = $clog2(STUFF_LEN + 1);

  enc_state_t       state_q, state_d;
  logic             level_q, level_d;
  logic             dp_q, dp_d, dm_q, dm_d;
  logic             stall_q, stall_d;
  logic             eop_q, eop_d;
  logic             err_q, err_d;
  logic             cnt_clear, cnt_inc, encode;
  logic [CNT_W-1:0] ones_cnt;
  logic             ones_full;
  logic [1:0]       raw;

  assign raw       = {raw_dp, raw_dm};
  assign ones_full = (ones_cnt == CNT_W'(STUFF_LEN));

  flex_counter #(
    .NUM_CNT_BITS(CNT_W)
  ) u_ones_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear_i       (cnt_clear),
    .count_enable_i(cnt_inc),
    .rollover_val_i(CNT_W'(STUFF_LEN)),
    .count_o       (ones_cnt)
  );

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    {dp_d, dm_d} = {dp_q, dm_q};
    stall_d   = stall_q;
    eop_d     = 1'b0;
    err_d     = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    encode    = 1'b0;

    // Abort wins over any strobe arriving in the same clk
    if ((state_q == ST_ACTIVE || state_q == ST_STUFF) && !tx_active) begin
      state_d      = ST_IDLE;
      level_d      = 1'b1;
      {dp_d, dm_d} = line_pins(LINE_J);
      stall_d      = 1'b0;
      cnt_clear    = 1'b1;
      err_d        = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          level_d      = 1'b1;
          {dp_d, dm_d} = line_pins(LINE_J);
          stall_d      = 1'b0;
          cnt_clear    = 1'b1;
          encode       = bit_strobe && tx_active;
        end
        ST_ACTIVE: begin
          if (ones_full) begin
            state_d = ST_STUFF;
            stall_d = 1'b1;
          end else begin
            encode = bit_strobe;
          end
        end
        ST_STUFF: begin
          if (bit_strobe) begin
            state_d      = ST_ACTIVE;
            level_d      = ~level_q;
            {dp_d, dm_d} = line_pins(level_to_line(~level_q));
            stall_d      = 1'b0;
            cnt_clear    = 1'b1;
          end
        end
        ST_SE0: begin
          cnt_clear = 1'b1;
          if (bit_strobe && (raw != 2'b00 || !tx_active)) begin
            state_d      = ST_EOP_J;
            level_d      = 1'b1;
            {dp_d, dm_d} = line_pins(LINE_J);
          end
        end
        ST_EOP_J: begin
          if (bit_strobe) begin
            state_d = ST_IDLE;
            eop_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // NRZI: data 0 toggles the line, data 1 (and illegal 11) holds it
    if (encode) begin
      state_d = ST_ACTIVE;
      unique case (raw)
        2'b01: begin
          level_d   = ~level_q;
          cnt_clear = 1'b1;
          cnt_inc   = 1'b0;
        end
        2'b00: begin
          state_d   = ST_SE0;
          cnt_clear = 1'b1;
          cnt_inc   = 1'b0;
        end
        default: begin
          cnt_clear = 1'b0;
          cnt_inc   = 1'b1;
          err_d     = (raw == 2'b11);
        end
      endcase
      {dp_d, dm_d} = (raw == 2'b00) ? line_pins(LINE_SE0) : line_pins(level_to_line(level_d));
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      level_q <= 1'b1;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
      stall_q <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      stall_q <= stall_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
    end
  end

  assign stall    = stall_q;
  assign dp_out   = dp_q;
  assign dm_out   = dm_q;
  assign eop_done = eop_q;
  assign line_err = err_q;

endmodule
